// File: rtl/apb_csr_regbank.sv
// rtl/apb_csr_regbank.sv - APB register bank feeding the CSR 8-to-1 read mux
module apb_csr_regbank #(
  parameter int                          ADDR_W      = 8,
  parameter int                          DATA_W      = 8,
  parameter int                          NUM_REGS    = 8,
  parameter int                          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]         RO_MASK     = 8'h00,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = 64'h0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   csr_q,
  output logic [2:0]                   mux_sel,
  output logic                         mux_en,
  input  logic [DATA_W-1:0]            mux_out
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                       state, state_nxt;
  logic [2:0]                   cnt, cnt_nxt;
  logic [ADDR_W-1:0]            addr_q;
  logic                         write_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [NUM_REGS*DATA_W-1:0]   regs;
  logic [2:0]                   sel_q;
  logic [IDX_W-1:0]             idx;
  logic                         setup;
  logic                         active;
  logic                         err;

  assign idx    = addr_q[IDX_W-1:0];
  assign setup  = psel && !penable;
  assign active = (state == ACCESS) && psel && penable;

  // Error decode and bus responses derived from the latched transfer
  always_comb begin
    err     = (addr_q >= ADDR_W'(NUM_REGS)) || (write_q && RO_MASK[idx]);
    pready  = active && (cnt == 3'd0);
    pslverr = pready && err;
    mux_en  = (state == ACCESS) && !write_q && !err;
    mux_sel = mux_en ? 3'(idx) : sel_q;
    prdata  = (pready && !write_q && !err) ? mux_out : '0;
    csr_q   = regs;
  end

  // Next-state and wait counter: an ACCESS that loses psel/penable aborts to IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = 3'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State register and SETUP-time capture of address, direction and data
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
    end
  end

  // Register file commits only on an error-free completing write
  always_ff @(posedge pclk) begin
    if (preset) begin
      regs <= RESET_VAL;
    end else if (pready && write_q && !err) begin
      regs[idx*DATA_W +: DATA_W] <= wdata_q;
    end
  end

  // Mux select holds the last read index once the read finishes
  always_ff @(posedge pclk) begin
    if (preset) begin
      sel_q <= 3'd0;
    end else if (mux_en) begin
      sel_q <= 3'(idx);
    end
  end

endmodule

// File: tb/tb_apb_csr_regbank.sv
// tb/tb_apb_csr_regbank.sv - directed checks of apb_csr_regbank on three configurations
module tb_apb_csr_regbank;

  localparam logic [63:0] RV1 = 64'h0000_005A_0000_0000;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel_v [3];
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic        pready_v [3];
  logic [7:0]  prdata_v [3];
  logic        pslverr_v [3];
  logic [63:0] csr_v [3];
  logic [2:0]  mux_sel_v [3];
  logic        mux_en_v [3];
  logic [7:0]  mux_out_v [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 pclk = ~pclk;

  // Behavioural 8-to-1 mux downstream of each bank
  for (genvar g = 0; g < 3; g++) begin : g_mux
    assign mux_out_v[g] = mux_en_v[g] ? csr_v[g][mux_sel_v[g]*8 +: 8] : 8'h00;
  end

  apb_csr_regbank #(.WAIT_STATES(0), .RO_MASK(8'h00), .RESET_VAL(64'h0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]),
    .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .csr_q(csr_v[0]),
    .mux_sel(mux_sel_v[0]), .mux_en(mux_en_v[0]), .mux_out(mux_out_v[0]));

  apb_csr_regbank #(.WAIT_STATES(3), .RO_MASK(8'h10), .RESET_VAL(RV1)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]),
    .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .csr_q(csr_v[1]),
    .mux_sel(mux_sel_v[1]), .mux_en(mux_en_v[1]), .mux_out(mux_out_v[1]));

  apb_csr_regbank #(.WAIT_STATES(2), .RO_MASK(8'h00), .RESET_VAL(64'h0)) dut2 (
    .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]),
    .prdata(prdata_v[2]), .pslverr(pslverr_v[2]), .csr_q(csr_v[2]),
    .mux_sel(mux_sel_v[2]), .mux_en(mux_en_v[2]), .mux_out(mux_out_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Full SETUP/ACCESS transfer; bus lines are scrambled after SETUP to prove latching
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, output logic [7:0] rd,
                          output logic err, output int lat, output logic [2:0] sel,
                          output logic en, output logic [63:0] csr_at);
    bit done = 0;
    rd = 8'hxx; err = 1'bx; lat = 0; sel = 3'bx; en = 1'bx; csr_at = 'x;
    @(posedge pclk); #1;
    psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1; pwrite = ~wr; paddr = ~addr; pwdata = ~data;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge pclk);
      if (pready_v[d]) begin
        rd = prdata_v[d]; err = pslverr_v[d]; sel = mux_sel_v[d];
        en = mux_en_v[d]; csr_at = csr_v[d]; done = 1;
      end else begin
        lat++;
        @(posedge pclk); #1;
      end
    end
    if (!done) check("pready_timeout", 64'd0, 64'd1);
    @(posedge pclk); #1;
    psel_v[d] = 1'b0; penable = 1'b0;
  endtask

  logic [7:0]  rd;
  logic        err;
  int          lat;
  logic [2:0]  sel;
  logic        en;
  logic [63:0] csr_at;

  initial begin
    preset = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    for (int i = 0; i < 3; i++) psel_v[i] = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("rst_pready", pready_v[0], 0);
    check("rst_prdata", prdata_v[0], 0);
    check("rst_pslverr", pslverr_v[0], 0);
    check("rst_csr0", csr_v[0], 0);
    check("rst_csr1", csr_v[1], RV1);
    check("rst_mux", {mux_en_v[0], mux_sel_v[0]}, 0);

    // penable without a preceding SETUP is ignored
    @(posedge pclk); #1;
    psel_v[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hEE;
    @(negedge pclk); check("noset_rdy0", pready_v[0], 0);
    @(posedge pclk); #1;
    @(negedge pclk); check("noset_rdy1", pready_v[0], 0);
    @(posedge pclk); #1; psel_v[0] = 1'b0; penable = 1'b0;
    @(negedge pclk); check("noset_csr", csr_v[0], 0);

    // Zero-wait writes and readback through the mux
    apb_xfer(0, 1, 8'd0, 8'hA5, rd, err, lat, sel, en, csr_at);
    check("w0_lat", lat, 0); check("w0_err", err, 0); check("w0_prdata", rd, 0);
    apb_xfer(0, 1, 8'd7, 8'h3C, rd, err, lat, sel, en, csr_at);
    check("w7_lat", lat, 0); check("w7_err", err, 0);
    check("w_csr", csr_v[0], 64'h3C00_0000_0000_00A5);
    apb_xfer(0, 0, 8'd0, 8'h00, rd, err, lat, sel, en, csr_at);
    check("r0_data", rd, 8'hA5); check("r0_lat", lat, 0);
    check("r0_mux", {en, sel}, {1'b1, 3'd0}); check("r0_err", err, 0);
    apb_xfer(0, 0, 8'd7, 8'h00, rd, err, lat, sel, en, csr_at);
    check("r7_data", rd, 8'h3C); check("r7_mux", {en, sel}, {1'b1, 3'd7});
    @(negedge pclk); check("sel_hold", {mux_en_v[0], mux_sel_v[0]}, {1'b0, 3'd7});

    // Out-of-range addresses
    apb_xfer(0, 1, 8'd8, 8'h11, rd, err, lat, sel, en, csr_at);
    check("w8_err", err, 1); check("w8_prdata", rd, 0);
    check("w8_csr", csr_v[0], 64'h3C00_0000_0000_00A5);
    apb_xfer(0, 0, 8'd9, 8'h00, rd, err, lat, sel, en, csr_at);
    check("r9_err", err, 1); check("r9_prdata", rd, 0); check("r9_mux_en", en, 0);

    // Wait states and commit timing
    apb_xfer(1, 1, 8'd2, 8'h55, rd, err, lat, sel, en, csr_at);
    check("ws3_lat", lat, 3); check("ws3_err", err, 0);
    check("ws3_pre", csr_at[23:16], 8'h00); check("ws3_post", csr_v[1][23:16], 8'h55);

    // Read-only register
    apb_xfer(1, 1, 8'd4, 8'hFF, rd, err, lat, sel, en, csr_at);
    check("ro_w_err", err, 1); check("ro_w_csr", csr_v[1], RV1 | 64'h0000_0000_0055_0000);
    apb_xfer(1, 0, 8'd4, 8'h00, rd, err, lat, sel, en, csr_at);
    check("ro_r_err", err, 0); check("ro_r_data", rd, 8'h5A); check("ro_r_lat", lat, 3);

    // Abort by dropping psel in the second ACCESS cycle
    @(posedge pclk); #1;
    psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd1; pwdata = 8'h77;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); check("abort_acc1", pready_v[2], 0);
    @(posedge pclk); #1; psel_v[2] = 1'b0;
    @(negedge pclk); check("abort_acc2", pready_v[2], 0);
    @(posedge pclk); #1; penable = 1'b0;
    @(negedge pclk); check("abort_idle", pready_v[2], 0);
    check("abort_csr", csr_v[2], 0);
    apb_xfer(2, 1, 8'd1, 8'h77, rd, err, lat, sel, en, csr_at);
    check("after_lat", lat, 2); check("after_err", err, 0);
    check("after_csr", csr_v[2], 64'h0000_0000_0000_7700);

    // Reset during ACCESS of a write
    @(posedge pclk); #1;
    psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 8'h99;
    @(posedge pclk); #1; penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1; preset = 1'b0; psel_v[0] = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("mid_rst_csr", csr_v[0], 0);
    check("mid_rst_out", {pready_v[0], pslverr_v[0], prdata_v[0]}, 0);
    check("mid_rst_mux", {mux_en_v[0], mux_sel_v[0]}, 0);
    check("mid_rst_csr1", csr_v[1], RV1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
